// File: rtl/echo_pkg.sv
// Shared definitions for the echo engine: FSM state encoding and the
// default converter offsets used as parameter defaults by the top level.
package echo_pkg;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        CALC  = 3'd3,
        WRITE = 3'd4
    } echo_state_e;

    localparam logic [9:0] ECHO_ADC_OFFSET = 10'h181;
    localparam logic [9:0] ECHO_DAC_OFFSET = 10'h200;

endpackage

// File: rtl/echo_dpram.sv
// Simple dual-port delay memory: one write port, one registered read port
// with one cycle of latency. A read and a write to the same address in the
// same cycle return the old contents (read-before-write).
module echo_dpram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read; non-blocking update gives old data on collision
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/echo_engine.sv
// Echo engine: accepts offset-binary ADC samples on a data_valid rising edge,
// subtracts an attenuated delayed copy taken from a circular delay memory and
// emits the offset-binary result. mode selects feedforward (store input) or
// feedback (store output) echo. After reset the whole delay memory is zeroed.
// Optional build macro: ECHO_ENGINE_SAT_EN -- saturate the echo result instead
// of letting it wrap.
module echo_engine
    import echo_pkg::*;
#(
    parameter int                DATA_W     = 10,
    parameter int                ADDR_W     = 13,
    parameter int                STEP_SHIFT = 4,
    parameter logic [DATA_W-1:0] ADC_OFFSET = ECHO_ADC_OFFSET,
    parameter logic [DATA_W-1:0] DAC_OFFSET = ECHO_DAC_OFFSET
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         data_valid,
    input  logic [ADDR_W-STEP_SHIFT-1:0] delay_sel,
    input  logic [1:0]                   gain_sel,
    input  logic                         mode,
    output logic [DATA_W-1:0]            data_out,
    output logic                         out_valid,
    output logic                         busy
);

    localparam int                DSEL_W    = ADDR_W - STEP_SHIFT;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    echo_state_e              state_q, state_d;
    logic                     dv_q;
    logic [ADDR_W-1:0]        clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0]        rptr_q, rptr_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] e_q, e_d;
    logic [DSEL_W-1:0]        dsel_q, dsel_d;
    logic [1:0]               gain_q, gain_d;
    logic                     mode_q, mode_d;
    logic [DATA_W-1:0]        data_out_q, data_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;

    logic                     accept_s;
    logic                     mem_we_s;
    logic                     mem_re_s;
    logic [ADDR_W-1:0]        mem_waddr_s;
    logic [DATA_W-1:0]        mem_wdata_s;
    logic [DATA_W-1:0]        mem_rdata_s;
    logic [2:0]               shamt_s;
    logic signed [DATA_W-1:0] e_shift_s;
    logic signed [DATA_W-1:0] y_s;
`ifdef ECHO_ENGINE_SAT_EN
    logic signed [DATA_W:0]   y_wide_s;
`endif

    echo_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (sysclk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .re    (mem_re_s),
        .raddr (rptr_q),
        .rdata (mem_rdata_s)
    );

    // Attenuated echo from the memory word and the latched gain
    always_comb begin
        shamt_s   = {1'b0, gain_q} + 3'd1;
        e_shift_s = $signed(mem_rdata_s) >>> shamt_s;
    end

    // Echo subtraction, wrapping by default or clamped when saturation is built in
    always_comb begin
`ifdef ECHO_ENGINE_SAT_EN
        y_wide_s = {x_q[DATA_W-1], x_q} - {e_q[DATA_W-1], e_q};
        if (y_wide_s[DATA_W] != y_wide_s[DATA_W-1]) begin
            y_s = y_wide_s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            y_s = y_wide_s[DATA_W-1:0];
        end
`else
        y_s = x_q - e_q;
`endif
    end

    // Next-state, datapath and memory-port control for the sample sequencer
    always_comb begin
        accept_s    = data_valid & ~dv_q & (state_q == IDLE);
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rptr_d      = rptr_q;
        x_d         = x_q;
        e_d         = e_q;
        dsel_d      = dsel_q;
        gain_d      = gain_q;
        mode_d      = mode_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_waddr_s = clr_addr_q;
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_addr_q;
                mem_wdata_s = {DATA_W{1'b0}};
                clr_addr_d  = clr_addr_q + ADDR_ONE;
                if (clr_addr_q == ADDR_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            IDLE: begin
                if (accept_s) begin
                    x_d      = data_in - ADC_OFFSET;
                    dsel_d   = delay_sel;
                    gain_d   = gain_sel;
                    mode_d   = mode;
                    mem_re_s = 1'b1;
                    state_d  = READ;
                end else begin
                    state_d  = IDLE;
                end
            end
            READ: begin
                // A zero delay would read the cell being rewritten; suppress the echo
                e_d     = (dsel_q == {DSEL_W{1'b0}}) ? {DATA_W{1'b0}} : e_shift_s;
                state_d = CALC;
            end
            CALC: begin
                data_out_d  = y_s + DAC_OFFSET;
                out_valid_d = 1'b1;
                mem_we_s    = 1'b1;
                mem_waddr_s = rptr_q + {dsel_q, {STEP_SHIFT{1'b0}}};
                mem_wdata_s = mode_q ? y_s : x_q;
                rptr_d      = rptr_q + ADDR_ONE;
                state_d     = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = CLEAR;
                clr_addr_d = {ADDR_W{1'b0}};
                busy_d     = 1'b1;
            end
        endcase
    end

    // State and output registers; reset restarts the memory clear from address 0
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            dv_q        <= 1'b0;
            clr_addr_q  <= {ADDR_W{1'b0}};
            rptr_q      <= {ADDR_W{1'b0}};
            x_q         <= {DATA_W{1'b0}};
            e_q         <= {DATA_W{1'b0}};
            dsel_q      <= {DSEL_W{1'b0}};
            gain_q      <= 2'd0;
            mode_q      <= 1'b0;
            data_out_q  <= DAC_OFFSET;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            dv_q        <= data_valid;
            clr_addr_q  <= clr_addr_d;
            rptr_q      <= rptr_d;
            x_q         <= x_d;
            e_q         <= e_d;
            dsel_q      <= dsel_d;
            gain_q      <= gain_d;
            mode_q      <= mode_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_echo_engine.sv
// Self-checking bench for echo_engine (default parameters). Directed vector
// tables with hand-computed results, a small reference model for the long
// run, and hand-written sequences for reset/clear/drop corner cases.
module tb_echo_engine;

    localparam int DEPTH = 8192;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [9:0] data_in;
    logic       data_valid;
    logic [8:0] delay_sel;
    logic [1:0] gain_sel;
    logic       mode;
    logic [9:0] data_out;
    logic       out_valid;
    logic       busy;

    always #5 sysclk = ~sysclk;

    echo_engine dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .delay_sel  (delay_sel),
        .gain_sel   (gain_sel),
        .mode       (mode),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    typedef struct {
        logic [9:0] din;
        logic [8:0] dsel;
        logic [1:0] gsel;
        logic       md;
        int         hold;
        int         exp;    // hand-computed data_out, -1 when only the model is checked
    } vec_t;

    int total = 0;
    int bad   = 0;
    int mmem [0:DEPTH-1];
    int mrp;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = 0;
        mrp = 0;
    endtask

    // Reference behaviour of one accepted sample; returns the expected data_out
    function automatic int model_step(input logic [9:0] din, input logic [8:0] dsel,
                                      input logic [1:0] g, input logic md);
        int xi, qi, ei, yi;
        xi = int'(din) - 385;
        if (xi > 511) xi = xi - 1024;
        qi = mmem[mrp];
        ei = (dsel == 9'd0) ? 0 : (qi >>> (int'(g) + 1));
        yi = xi - ei;
`ifdef ECHO_ENGINE_SAT_EN
        if (yi > 511) yi = 511;
        if (yi < -512) yi = -512;
`else
        if (yi > 511) yi = yi - 1024;
        if (yi < -512) yi = yi + 1024;
`endif
        mmem[(mrp + int'(dsel) * 16) % DEPTH] = md ? yi : xi;
        mrp = (mrp + 1) % DEPTH;
        return yi + 512;
    endfunction

    // Drive one sample (called at a negedge), scramble the controls after acceptance
    task automatic do_sample(input vec_t v, input string name);
        int mexp;
        int pulses;
        int pos;
        int got;
        mexp   = model_step(v.din, v.dsel, v.gsel, v.md);
        pulses = 0;
        pos    = 0;
        got    = 0;
        data_in    = v.din;
        delay_sel  = v.dsel;
        gain_sel   = v.gsel;
        mode       = v.md;
        data_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge sysclk);
            if (c == 1) begin
                data_in   = ~v.din;
                delay_sel = ~v.dsel;
                gain_sel  = ~v.gsel;
                mode      = ~v.md;
            end
            if (c == v.hold) data_valid = 1'b0;
            if (out_valid) begin
                pulses++;
                pos = c;
                got = int'(data_out);
            end
        end
        check({name, " pulses"}, pulses, 1);
        check({name, " latency"}, pos, 3);
        check({name, " model"}, got, mexp);
        if (v.exp >= 0) check({name, " hand"}, got, v.exp);
    endtask

    // Release reset and time the memory clear; optionally pulse data_valid during it
    task automatic clear_run(input string name, input int pulse_at);
        int n;
        int ov;
        n  = 0;
        ov = 0;
        rst = 1'b0;
        while (n < 9000) begin
            @(posedge sysclk);
            n++;
            @(negedge sysclk);
            data_valid = (n == pulse_at);
            if (out_valid) ov++;
            if (!busy) break;
        end
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            if (out_valid) ov++;
        end
        check({name, " busy cycles"}, n, 8192);
        check({name, " no out_valid"}, ov, 0);
        check({name, " busy low"}, int'(busy), 0);
    endtask

    initial begin
        vec_t va[$];
        vec_t vb[$];
        vec_t v;
        int   pulses;
        int   pos;
        int   got;
        int   mexp;

        // Table A: zero delay, feedforward impulse, feedback impulse
        va.push_back('{10'd485, 9'd0, 2'd0, 1'b0, 3, 612});
        for (int i = 0; i <= 32; i++) begin
            v = '{(i == 0) ? 10'd585 : 10'd385, 9'd1, 2'd0, 1'b0, 1 + (i % 3),
                  (i == 0) ? 712 : (i == 16) ? 412 : (i == 32) ? 512 : -1};
            va.push_back(v);
        end
        for (int i = 0; i <= 48; i++) begin
            v = '{(i == 0) ? 10'd585 : 10'd385, 9'd1, 2'd0, 1'b1, 1 + (i % 3),
                  (i == 0) ? 712 : (i == 16) ? 412 : (i == 32) ? 562 : (i == 48) ? 487 : -1};
            va.push_back(v);
        end
        // Table B (fresh memory): overflow of x - e
        for (int i = 0; i <= 16; i++) begin
            v = '{(i == 0) ? 10'd897 : (i == 16) ? 10'd896 : 10'd385, 9'd1, 2'd0, 1'b0, 3,
`ifdef ECHO_ENGINE_SAT_EN
                  (i == 0) ? 0 : (i == 16) ? 1023 : -1};
`else
                  (i == 0) ? 0 : (i == 16) ? 255 : -1};
`endif
            vb.push_back(v);
        end

        rst        = 1'b1;
        data_in    = 10'd0;
        data_valid = 1'b0;
        delay_sel  = 9'd0;
        gain_sel   = 2'd0;
        mode       = 1'b0;
        repeat (3) @(negedge sysclk);
        check("reset data_out", int'(data_out), 512);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 1);

        clear_run("clear1", 100);
        model_reset();

        for (int i = 0; i < va.size(); i++) do_sample(va[i], $sformatf("vecA%0d", i));

        // Rising edge while a sample is in flight is dropped
        mexp   = model_step(10'd600, 9'd2, 2'd1, 1'b0);
        pulses = 0;
        pos    = 0;
        got    = 0;
        data_in = 10'd600; delay_sel = 9'd2; gain_sel = 2'd1; mode = 1'b0; data_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge sysclk);
            if (c == 1) data_valid = 1'b0;
            if (c == 2) begin data_valid = 1'b1; data_in = 10'd900; end
            if (c == 6) data_valid = 1'b0;
            if (out_valid) begin pulses++; pos = c; got = int'(data_out); end
        end
        check("drop pulses", pulses, 1);
        check("drop latency", pos, 3);
        check("drop value", got, mexp);
        do_sample('{10'd400, 9'd2, 2'd1, 1'b0, 2, -1}, "after drop");

        // Reset in the middle of a sample, then again in the middle of the clear
        data_in = 10'd500; delay_sel = 9'd1; gain_sel = 2'd0; mode = 1'b0; data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        check("abort out_valid", int'(out_valid), 0);
        check("abort data_out", int'(data_out), 512);
        check("abort busy", int'(busy), 1);
        rst = 1'b0;
        repeat (3000) @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        check("midclear busy", int'(busy), 1);
        clear_run("clear2", 0);
        model_reset();

        for (int i = 0; i < vb.size(); i++) do_sample(vb[i], $sformatf("vecB%0d", i));

        // Long run across the pointer wrap with delay, gain and mode changes
        for (int k = 0; k < 8200; k++) begin
            v.din  = 10'($urandom_range(0, 1023));
            v.dsel = (k < 4100) ? 9'd1 : 9'd3;
            v.gsel = 2'($urandom_range(0, 3));
            v.md   = ((k / 1000) % 2) == 1;
            v.hold = 3;
            v.exp  = -1;
            do_sample(v, $sformatf("long%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/echo_engine.md
ECHO_ENGINE -- requirements
Module: echo_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 10, sample width.
- ADDR_W, 13, delay-memory address width; depth is 2^ADDR_W.
- STEP_SHIFT, 4, delay granularity; delay in samples is delay_sel << STEP_SHIFT.
- ADC_OFFSET, 10'h181, input offset.
- DAC_OFFSET, 10'h200, output offset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- sysclk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- data_in, in, DATA_W, offset-binary ADC sample.
- data_valid, in, 1, sample strobe, synchronous to sysclk, may stay high for several cycles.
- delay_sel, in, ADDR_W-STEP_SHIFT, echo delay select.
- gain_sel, in, 2, echo attenuation; arithmetic shift right by gain_sel+1.
- mode, in, 1, 0 = feedforward echo, 1 = feedback (recirculating) echo.
- data_out, out, DATA_W, offset-binary DAC sample.
- out_valid, out, 1, one-cycle pulse when data_out updates.
- busy, out, 1, memory clear in progress.
REQ-003 The block SHALL use one clock, sysclk, with an asynchronous active-high reset, rst.

Function
REQ-004 A sample SHALL be accepted on the first sysclk cycle in which data_valid is 1 after being 0 (rising-edge detect on a registered copy); further high cycles SHALL be ignored.
REQ-005 On acceptance (cycle E):
- x = data_in - ADC_OFFSET, two's complement.
- delay_sel, gain_sel and mode SHALL be latched for that sample.
- A memory read SHALL be issued at rptr.
REQ-006 At E+1, e = q >>> (gain_sel+1), arithmetic shift.
REQ-007 At E+2:
- y = x - e.
- data_out SHALL equal y + DAC_OFFSET, with out_valid = 1 for exactly one cycle.
- The memory SHALL be written at wraddr = rptr + (delay_sel << STEP_SHIFT), modulo 2^ADDR_W.
- The written value SHALL be x when mode = 0 and y when mode = 1.
- rptr SHALL increment, wrapping from 2^ADDR_W-1 to 0.
REQ-008 When delay_sel = 0, the block SHALL force e = 0 (y = x) and SHALL still perform the write.
REQ-009 The FSM SHALL have the states CLEAR, IDLE, READ, CALC and WRITE, with transitions:
- CLEAR -> IDLE after the last address is written.
- IDLE -> READ on acceptance.
- READ -> CALC.
- CALC -> WRITE.
- WRITE -> IDLE.
REQ-010 A data_valid rising edge that arrives while not in IDLE SHALL be dropped, with no out_valid.
REQ-011 Changes to delay_sel, gain_sel or mode between samples SHALL take effect at the next acceptance only.
REQ-012 All arithmetic SHALL be DATA_W-bit two's complement; overflow behaviour is set by REQ-016.

Reset
REQ-013 While rst = 1, the block SHALL hold:
- rptr = 0, data_out = DAC_OFFSET, out_valid = 0.
- busy = 1, FSM = CLEAR, edge-detect register = 0.
REQ-014 After rst falls, CLEAR SHALL write 0 to every address, one per cycle, over 2^ADDR_W cycles, with busy = 1 throughout; data_valid SHALL be ignored during CLEAR.
REQ-015 An rst asserted mid-sample or mid-CLEAR SHALL abort that operation; CLEAR SHALL restart from address 0 after rst falls.

Configuration
REQ-016 With ECHO_ENGINE_SAT_EN defined, y SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before it is output and stored. Without the macro, y SHALL wrap modulo 2^DATA_W.

Structure
REQ-017 A shared package echo_pkg SHALL hold the FSM state enumeration and the default ADC_OFFSET and DAC_OFFSET constants.
REQ-018 The memory SHALL be a sub-module echo_dpram with these properties:
- simple dual-port, DATA_W x 2^ADDR_W.
- registered read with 1-cycle latency.
- read-before-write on address collision.

Verification (defaults)
REQ-019 Assert rst, release it, then pulse data_valid at release+100 -> busy = 1 for 8192 cycles then 0; no out_valid is produced for that pulse.
REQ-020 delay_sel = 0, data_in = 485 -> data_out = 612 with out_valid, 2 cycles after the edge cycle.
REQ-021 mode = 0, delay_sel = 1, gain_sel = 0; impulse data_in = 585 then data_in = 385:
- sample 0 -> data_out = 712.
- sample 16 -> data_out = 412.
- sample 32 -> data_out = 512.
REQ-022 mode = 1, same impulse stimulus:
- sample 16 -> data_out = 412.
- sample 32 -> data_out = 562.
- sample 48 -> data_out = 487.
REQ-023 mode = 0, delay_sel = 1, gain_sel = 0; data_in = 897 (x = -512), then 15 samples at data_in = 385, then data_in = 896 (x = 511):
- with ECHO_ENGINE_SAT_EN -> data_out = 1023.
- without ECHO_ENGINE_SAT_EN -> data_out = 255.
REQ-024 Run 8200 samples with delay_sel changed mid-stream and data_valid held high for 3 cycles per sample -> exactly one out_valid per sample; rptr wraps at 8192 with no glitch; the new delay applies from the next sample.
